// File: rtl/tcam_param.sv
// Parametrised ternary CAM: runtime-writable value/mask table with a three-stage
// lookup pipeline returning the lowest-index hit plus hit and multi-hit flags.
module tcam_param #(
    parameter int KEY_W = 4,
    parameter int DEPTH = 16,
    parameter int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             key_in_vld,
    input  logic [KEY_W-1:0] key_in,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_addr,
    input  logic [KEY_W-1:0] wr_key,
    input  logic [KEY_W-1:0] wr_mask,
    input  logic             wr_valid,
    input  logic             tbl_clr,
    output logic             tcam_out_vld,
    output logic             tcam_out_hit,
    output logic             tcam_out_multi,
    output logic [IDX_W-1:0] tcam_out
);

    function automatic logic [IDX_W-1:0] prio_enc(input logic [DEPTH-1:0] m);
        logic [IDX_W-1:0] idx;
        idx = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (m[i]) idx = IDX_W'(i);
        end
        return idx;
    endfunction

    function automatic logic multi_hit(input logic [DEPTH-1:0] m);
        logic seen;
        logic multi;
        seen  = 1'b0;
        multi = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (m[i]) begin
                if (seen) multi = 1'b1;
                seen = 1'b1;
            end
        end
        return multi;
    endfunction

    logic [KEY_W-1:0] val_q [DEPTH];
    logic [KEY_W-1:0] msk_q [DEPTH];
    logic [DEPTH-1:0] ent_vld;

    // Clear beats a same-cycle write; addresses beyond DEPTH decode to no entry.
    always_ff @(posedge clk) begin
        if (!reset) begin
            ent_vld <= '0;
        end else if (tbl_clr) begin
            ent_vld <= '0;
        end else if (wr_en) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (wr_addr == IDX_W'(i)) ent_vld[i] <= wr_valid;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en && !tbl_clr) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (wr_addr == IDX_W'(i)) begin
                    val_q[i] <= wr_key & wr_mask;
                    msk_q[i] <= wr_mask;
                end
            end
        end
    end

    // S1: register the key
    logic             vld_p0;
    logic [KEY_W-1:0] key_p0;

    always_ff @(posedge clk) begin
        if (!reset) vld_p0 <= 1'b0;
        else        vld_p0 <= key_in_vld;
    end

    always_ff @(posedge clk) begin
        key_p0 <= key_in_vld ? key_in : '0;
    end

    // S2: per-entry compare against the table as it stands before this edge
    logic [DEPTH-1:0] match_vec;
    logic             vld_p1;
    logic [DEPTH-1:0] match_p1;

    always_comb begin
        match_vec = '0;
        for (int i = 0; i < DEPTH; i++) begin
            match_vec[i] = ent_vld[i] && ((key_p0 & msk_q[i]) == val_q[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) vld_p1 <= 1'b0;
        else        vld_p1 <= vld_p0;
    end

    always_ff @(posedge clk) begin
        match_p1 <= vld_p0 ? match_vec : '0;
    end

    // S3: priority encode into the output registers
    always_ff @(posedge clk) begin
        if (!reset) begin
            tcam_out_vld   <= 1'b0;
            tcam_out_hit   <= 1'b0;
            tcam_out_multi <= 1'b0;
            tcam_out       <= '0;
        end else begin
            tcam_out_vld   <= vld_p1;
            tcam_out_hit   <= vld_p1 && (|match_p1);
            tcam_out_multi <= vld_p1 && multi_hit(match_p1);
            tcam_out       <= vld_p1 ? prio_enc(match_p1) : '0;
        end
    end

endmodule

// File: tb/tb_tcam_param.sv
// Directed bench for tcam_param (KEY_W=4, DEPTH=16): table-driven lookups plus
// hand-written pipeline, write-visibility, clear and reset sequences.
module tb_tcam_param;

    logic       clk;
    logic       reset;
    logic       key_in_vld;
    logic [3:0] key_in;
    logic       wr_en;
    logic [3:0] wr_addr;
    logic [3:0] wr_key;
    logic [3:0] wr_mask;
    logic       wr_valid;
    logic       tbl_clr;
    logic       tcam_out_vld;
    logic       tcam_out_hit;
    logic       tcam_out_multi;
    logic [3:0] tcam_out;

    int n_cmp = 0;
    int n_err = 0;

    tcam_param #(.KEY_W(4), .DEPTH(16)) dut (
        .clk(clk), .reset(reset), .key_in_vld(key_in_vld), .key_in(key_in),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_key(wr_key), .wr_mask(wr_mask),
        .wr_valid(wr_valid), .tbl_clr(tbl_clr), .tcam_out_vld(tcam_out_vld),
        .tcam_out_hit(tcam_out_hit), .tcam_out_multi(tcam_out_multi), .tcam_out(tcam_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       do_wr;
        logic [3:0] wa;
        logic [3:0] wk;
        logic [3:0] wm;
        logic       wv;
        logic [3:0] key;
        logic       hit;
        logic       multi;
        logic [3:0] idx;
    } vec_t;

    vec_t vecs [9];

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic check_res(input string nm, input logic v, input logic h,
                             input logic m, input logic [3:0] i);
        chk({nm, "_vld"},   8'(tcam_out_vld),   8'(v));
        chk({nm, "_hit"},   8'(tcam_out_hit),   8'(h));
        chk({nm, "_multi"}, 8'(tcam_out_multi), 8'(m));
        chk({nm, "_idx"},   8'(tcam_out),       8'(i));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Any write/clear already driven by the caller is sampled on the same edge as the key.
    task automatic lookup(input string nm, input logic [3:0] k, input logic h,
                          input logic m, input logic [3:0] i);
        key_in_vld = 1'b1;
        key_in     = k;
        step();
        key_in_vld = 1'b0;
        wr_en      = 1'b0;
        tbl_clr    = 1'b0;
        step();
        chk({nm, "_early_vld"}, 8'(tcam_out_vld), 8'd0);
        step();
        check_res(nm, 1'b1, h, m, i);
    endtask

    task automatic wr(input logic [3:0] a, input logic [3:0] k, input logic [3:0] m,
                      input logic v);
        wr_en = 1'b1; wr_addr = a; wr_key = k; wr_mask = m; wr_valid = v;
        step();
        wr_en = 1'b0;
    endtask

    task automatic run_vecs(input int lo, input int hi);
        for (int n = lo; n <= hi; n++) begin
            if (vecs[n].do_wr) wr(vecs[n].wa, vecs[n].wk, vecs[n].wm, vecs[n].wv);
            lookup($sformatf("vec%0d", n), vecs[n].key, vecs[n].hit, vecs[n].multi, vecs[n].idx);
        end
    endtask

    initial begin
        // do_wr addr key mask valid | lookup key | hit multi idx
        vecs[0] = '{1'b1, 4'd4,  4'h5, 4'hF, 1'b1, 4'h5, 1'b1, 1'b0, 4'd4};
        vecs[1] = '{1'b1, 4'd9,  4'h4, 4'hE, 1'b1, 4'h5, 1'b1, 1'b1, 4'd4};
        vecs[2] = '{1'b0, 4'd0,  4'h0, 4'h0, 1'b0, 4'h4, 1'b1, 1'b0, 4'd9};
        vecs[3] = '{1'b0, 4'd0,  4'h0, 4'h0, 1'b0, 4'hF, 1'b0, 1'b0, 4'd0};
        vecs[4] = '{1'b0, 4'd0,  4'h0, 4'h0, 1'b0, 4'h7, 1'b0, 1'b0, 4'd0};
        vecs[5] = '{1'b1, 4'd12, 4'h9, 4'h0, 1'b1, 4'h7, 1'b1, 1'b0, 4'd12};
        vecs[6] = '{1'b1, 4'd13, 4'h7, 4'hF, 1'b1, 4'h7, 1'b1, 1'b1, 4'd12};
        vecs[7] = '{1'b0, 4'd0,  4'h0, 4'h0, 1'b0, 4'h3, 1'b1, 1'b0, 4'd12};
        vecs[8] = '{1'b1, 4'd12, 4'h0, 4'h0, 1'b0, 4'h7, 1'b1, 1'b0, 4'd13};

        reset = 1'b0; key_in_vld = 1'b0; key_in = '0; wr_en = 1'b0; wr_addr = '0;
        wr_key = '0; wr_mask = '0; wr_valid = 1'b0; tbl_clr = 1'b0;

        // Scenario 1: reset, empty table
        step();
        step();
        check_res("in_reset", 1'b0, 1'b0, 1'b0, 4'd0);
        reset = 1'b1;
        step();
        check_res("post_reset", 1'b0, 1'b0, 1'b0, 4'd0);
        lookup("empty_5", 4'h5, 1'b0, 1'b0, 4'd0);

        // Scenario 2 via table
        run_vecs(0, 4);

        // Scenario 3: back-to-back lookups
        key_in_vld = 1'b1; key_in = 4'h5;
        step();
        key_in = 4'h4;
        step();
        key_in = 4'h7;
        step();
        check_res("b2b_0", 1'b1, 1'b1, 1'b1, 4'd4);
        key_in_vld = 1'b0;
        step();
        check_res("b2b_1", 1'b1, 1'b1, 1'b0, 4'd9);
        step();
        check_res("b2b_2", 1'b1, 1'b0, 1'b0, 4'd0);
        step();
        chk("b2b_tail_vld", 8'(tcam_out_vld), 8'd0);

        // Scenario 4: write on the lookup edge is visible
        wr_en = 1'b1; wr_addr = 4'd2; wr_key = 4'hA; wr_mask = 4'hF; wr_valid = 1'b1;
        lookup("same_edge_wr", 4'hA, 1'b1, 1'b0, 4'd2);
        tbl_clr = 1'b1;
        step();
        tbl_clr = 1'b0;
        key_in_vld = 1'b1; key_in = 4'hA;
        step();
        key_in_vld = 1'b0;
        wr_en = 1'b1; wr_addr = 4'd2; wr_key = 4'hA; wr_mask = 4'hF; wr_valid = 1'b1;
        step();
        wr_en = 1'b0;
        step();
        check_res("late_wr", 1'b1, 1'b0, 1'b0, 4'd0);
        lookup("after_late_wr", 4'hA, 1'b1, 1'b0, 4'd2);

        // Scenario 5: clear wins over write, delete entry 15
        tbl_clr = 1'b1;
        wr_en = 1'b1; wr_addr = 4'd3; wr_key = 4'h1; wr_mask = 4'hF; wr_valid = 1'b1;
        step();
        tbl_clr = 1'b0; wr_en = 1'b0;
        lookup("clr_5", 4'h5, 1'b0, 1'b0, 4'd0);
        lookup("clr_1", 4'h1, 1'b0, 1'b0, 4'd0);
        lookup("clr_A", 4'hA, 1'b0, 1'b0, 4'd0);
        wr(4'd15, 4'hC, 4'hF, 1'b1);
        lookup("ent15_hit", 4'hC, 1'b1, 1'b0, 4'd15);
        wr(4'd15, 4'hC, 4'hF, 1'b0);
        lookup("ent15_del", 4'hC, 1'b0, 1'b0, 4'd0);

        // All-zero mask entries and priority among them
        run_vecs(5, 8);

        // Scenario 6: reset with two lookups in flight
        key_in_vld = 1'b1; key_in = 4'h7;
        step();
        step();
        key_in_vld = 1'b0;
        reset = 1'b0;
        step();
        check_res("rst_flight_0", 1'b0, 1'b0, 1'b0, 4'd0);
        reset = 1'b1;
        step();
        check_res("rst_flight_1", 1'b0, 1'b0, 1'b0, 4'd0);
        step();
        check_res("rst_flight_2", 1'b0, 1'b0, 1'b0, 4'd0);
        lookup("rst_empty_7", 4'h7, 1'b0, 1'b0, 4'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/tcam_param.md
# tcam_param

Parametrised ternary CAM for the match-action lookup path. Holds DEPTH entries of KEY_W-bit value/mask pairs with per-entry valid bits, all writable at runtime. Performs one fully pipelined lookup per cycle and returns the lowest-index matching entry, a hit flag and a multi-hit flag. Generalises the fixed 4-bit/16-entry, reset-preloaded table to arbitrary width and depth with a live update port.

## Interface
Parameters:
- KEY_W, 4, key and mask width in bits (≥1)
- DEPTH, 16, number of entries (≥2, need not be a power of two)
- IDX_W, max(1, $clog2(DEPTH)), result/address index width (derived, not overridden)

Ports:
- clk  in  1  single clock, all logic on rising edge
- reset  in  1  synchronous, active-low; asserted (0) clears all state on the next rising edge
- key_in_vld  in  1  lookup request qualifier; no backpressure
- key_in  in  KEY_W  lookup key
- wr_en  in  1  table write strobe
- wr_addr  in  IDX_W  entry to write
- wr_key  in  KEY_W  entry value
- wr_mask  in  KEY_W  entry mask; bit=1 means care, 0 means don't care
- wr_valid  in  1  entry valid bit written with the entry (0 deletes it)
- tbl_clr  in  1  invalidate all entries in one cycle
- tcam_out_vld  out  1  result qualifier, one pulse per accepted lookup
- tcam_out_hit  out  1  at least one valid entry matched
- tcam_out_multi  out  1  two or more valid entries matched
- tcam_out  out  IDX_W  lowest matching index; 0 when no hit

## Operation
- Table: per entry val[i], msk[i], ent_vld[i]. Write stores val = wr_key & wr_mask, msk = wr_mask, ent_vld = wr_valid.
- wr_addr ≥ DEPTH: write ignored, no entry changes.
- tbl_clr: clears every ent_vld; val/msk are don't care. tbl_clr and wr_en in the same cycle: tbl_clr wins and the write is dropped.
- Match for entry i: ent_vld[i] && ((key & msk[i]) == val[i]). An all-zero mask on a valid entry matches every key.
- Priority: the lowest index wins. multi = popcount(match) ≥ 2.
- Reset: all ent_vld=0, pipeline valids=0, and every output 0 (vld, hit, multi, tcam_out). The table comes up empty. There are no preloaded entries.
- When a stage has no valid input, it forces its outputs to 0. When tcam_out_vld=0, then tcam_out_hit, tcam_out_multi and tcam_out are all 0.

## Timing
- Three register stages:
  - S1: key_r/v1 sampled from key_in/key_in_vld.
  - S2: match vector and v2.
  - S3: priority encode into the outputs.
- Latency: a key sampled at edge k produces a registered result at edge k+2. Outputs are valid in the cycle after edge k+2.
- Throughput: one lookup per cycle with no bubbles. Back-to-back requests produce back-to-back results in order.
- Write visibility:
  - A write or clear sampled at edge w updates the table at w.
  - A lookup sampled at edge k sees writes with w ≤ k, because the compare at edge k+1 uses the post-w table.
  - Writes at w ≥ k+1 are not seen by that lookup.
- Lookups and writes run concurrently with no stall and no ready signal.
- Reset asserted mid-flight: all in-flight lookups are discarded. No tcam_out_vld pulse appears for them, including during the cycle after reset deasserts.
- No combinational path from any input to any output.

## Test plan
Parameters KEY_W=4, DEPTH=16.
1. Reset low for 2 cycles, then release. Check all outputs are 0. Look up 0x5 at edge k: at edge k+2 expect vld=1, hit=0, multi=0, tcam_out=0.
2. Write entry 4 = key 0x5 / mask 0xF and entry 9 = key 0x4 / mask 0xE. Look up 0x5: expect hit=1, tcam_out=4, multi=1. Look up 0x4: expect hit=1, tcam_out=9, multi=0.
3. Using the table from scenario 2, issue lookups 0x5, 0x4, 0x7 on consecutive cycles. Expect three consecutive vld pulses with (hit, idx) = (1,4), (1,9), (0,0).
4. Write entry 2 = 0xA / 0xF on the same edge as the 0xA lookup: expect hit, idx 2. Repeat with the write one edge after the lookup on a fresh table: expect a miss. The next lookup of 0xA hits idx 2.
5. Assert tbl_clr together with wr_en (addr 3, key 0x1, mask 0xF, valid 1). Lookups of 0x5 and 0x1 both miss. Write wr_addr=0xF with wr_valid=0 to delete that entry; a lookup matching only entry 15 then misses.
6. Issue lookups on 2 consecutive cycles, then pull reset low for 1 cycle before their results emerge. Expect no vld pulse. After reset releases, the table is empty and any lookup misses.
